mips_store_monitor: RTL and testbench

//  Sits directly downstream of the single-cycle MIPS top and watches its data-memory store bus
//  (memwrite/dataadr/writedata). Each store is logged into a FIFO trace that a host or bench

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mips_store_monitor_if.sv | 27 ++
 rtl/trace_fifo.sv | 62 ++++++
 rtl/mips_store_monitor.sv | 92 +++++++++
 tb/tb_mips_store_monitor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS store monitor.
//   state_t        verdict FSM encoding (RUN / PASS / FAIL)
//   trace_entry_t  one logged store: {addr, data}, 64 bits
//   *_DEF          default pass/allow signature constants
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OVF_W  = 16;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PASS_ADDR_DEF  = 32'd84;
  localparam logic [DATA_W-1:0] PASS_DATA_DEF  = 32'd7;
  localparam logic [ADDR_W-1:0] ALLOW_ADDR_DEF = 32'd80;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/mips_store_monitor_if.sv
// Store-bus and trace-stream signals between the processor/consumer and the monitor.
//   memwrite/dataadr/writedata  processor store bus
//   out_valid/out_ready         trace head handshake
//   out_addr/out_data           trace head payload
// master = processor + trace consumer side, slave = monitor side.
interface mips_store_monitor_if;
  import mips_pkg::*;

  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output memwrite, dataadr, writedata, out_ready,
    input  out_valid, out_addr, out_data
  );

  modport slave (
    input  memwrite, dataadr, writedata, out_ready,
    output out_valid, out_addr, out_data
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries, DEPTH deep (power of 2).
//   clk, rst_n     clock, async active-low reset (pointers/count only)
//   push, wdata    enqueue request; accepted when not full or when popping
//   pop            dequeue request; ignored when empty
//   head           entry at the read pointer (combinational from storage)
//   full, empty    occupancy flags
//   count          entries held, 0..DEPTH
module trace_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  trace_entry_t           wdata,
  output trace_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mips_store_monitor.sv
// Watches the MIPS data-memory store bus, logs every store made while the verdict
// is still open into a trace FIFO, and decides pass/fail from the store stream.
//   clk, reset     clock, async active-low reset
//   bus            store bus in, trace head stream out (slave modport)
//   count          trace entries held
//   overflow_cnt   stores dropped on a full trace, saturating
//   done, pass     verdict reached / verdict is pass
module mips_store_monitor
  import mips_pkg::*;
#(
  parameter int unsigned       DEPTH      = 8,
  parameter logic [ADDR_W-1:0] PASS_ADDR  = PASS_ADDR_DEF,
  parameter logic [DATA_W-1:0] PASS_DATA  = PASS_DATA_DEF,
  parameter logic [ADDR_W-1:0] ALLOW_ADDR = ALLOW_ADDR_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_store_monitor_if.slave    bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic                   done,
  output logic                   pass
);

  state_t       state_q;
  state_t       state_d;
  logic         done_d;
  logic         pass_d;
  logic         push;
  logic         full;
  logic         empty;
  trace_entry_t wdata;
  trace_entry_t head;

  // Only stores seen while the verdict is open are logged, including the deciding one.
  assign push  = bus.memwrite && (state_q == S_RUN);
  assign wdata = '{addr: bus.dataadr, data: bus.writedata};

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (bus.out_ready),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.out_valid = !empty;
  assign bus.out_addr  = head.addr;
  assign bus.out_data  = head.data;

  // Verdict next-state; done/pass are registered from the next state.
  always_comb begin
    state_d = state_q;
    if ((state_q == S_RUN) && bus.memwrite) begin
      if ((bus.dataadr == PASS_ADDR) && (bus.writedata == PASS_DATA)) begin
        state_d = S_PASS;
      end else if (bus.dataadr != ALLOW_ADDR) begin
        state_d = S_FAIL;
      end
    end
    done_d = (state_d != S_RUN);
    pass_d = (state_d == S_PASS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      pass    <= pass_d;
    end
  end

  // A push is dropped only when full with no pop (full implies non-empty).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_cnt <= '0;
    end else if (push && full && !bus.out_ready && (overflow_cnt != '1)) begin
      overflow_cnt <= overflow_cnt + OVF_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_store_monitor.sv
module tb_mips_store_monitor;

  localparam int unsigned DEPTH = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  count;
  logic [15:0] overflow_cnt;
  logic        done;
  logic        pass;

  mips_store_monitor_if bus ();

  mips_store_monitor #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .count        (count),
    .overflow_cnt (overflow_cnt),
    .done         (done),
    .pass         (pass)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: trace as a queue, verdict as two flags.
  logic [63:0] mq[$];
  bit          m_done = 1'b0;
  bit          m_pass = 1'b0;
  int unsigned m_ovf  = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        m_done = 1'b0;
        m_pass = 1'b0;
        m_ovf  = 0;
      end else begin
        int unsigned held;
        bit popped;
        popped = (mq.size() != 0) && (bus.out_ready === 1'b1);
        held   = mq.size() - (popped ? 1 : 0);
        if (popped) void'(mq.pop_front());
        if (bus.memwrite === 1'b1 && !m_done) begin
          if (held < DEPTH) mq.push_back({bus.dataadr, bus.writedata});
          else if (m_ovf < 65535) m_ovf++;
          if (bus.dataadr == 32'd84 && bus.writedata == 32'd7) begin
            m_done = 1'b1;
            m_pass = 1'b1;
          end else if (bus.dataadr != 32'd80) begin
            m_done = 1'b1;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("overflow", 32'(overflow_cnt), m_ovf);
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_pass));
      if (mq.size() != 0) begin
        chk("head_addr", bus.out_addr, mq[0][63:32]);
        chk("head_data", bus.out_data, mq[0][31:0]);
      end
    end
  end

  // Store on the next rising edge; returns at the following falling edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.dataadr   = a;
    bus.writedata = d;
    @(negedge clk);
    bus.memwrite  = 1'b0;
  endtask

  // Async reset pulse between edges (called just after a falling edge).
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.out_ready = 1'b0;

    // 1: pass signature with out_ready low
    #22 reset = 1'b1;
    @(negedge clk);
    chk("t1_reset_count", 32'(count), 32'd0);
    chk("t1_reset_done", 32'(done), 32'd0);
    store(32'd80, 32'd5);
    store(32'd84, 32'd7);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_count", 32'(count), 32'd2);
    chk("t1_head0_addr", bus.out_addr, 32'd80);
    chk("t1_head0_data", bus.out_data, 32'd5);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_head1_addr", bus.out_addr, 32'd84);
    chk("t1_head1_data", bus.out_data, 32'd7);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t1_drained", 32'(count), 32'd0);

    // 2: fail on a disallowed address; later stores ignored
    pulse_reset();
    store(32'd80, 32'd1);
    store(32'd88, 32'd3);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_count", 32'(count), 32'd2);
    store(32'd80, 32'd2);
    store(32'd84, 32'd7);
    chk("t2_count_after", 32'(count), 32'd2);
    chk("t2_ovf_after", 32'(overflow_cnt), 32'd0);
    chk("t2_pass_after", 32'(pass), 32'd0);

    // 3: overflow
    pulse_reset();
    for (int i = 0; i < 10; i++) store(32'd80, 32'(i));
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_ovf", 32'(overflow_cnt), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", bus.out_data, 32'(i));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("t3_empty", 32'(bus.out_valid), 32'd0);

    // 4: full with simultaneous push and pop
    pulse_reset();
    for (int i = 0; i < 8; i++) store(32'd80, 32'(16 + i));
    bus.out_ready = 1'b1;
    store(32'd80, 32'hA);
    bus.out_ready = 1'b0;
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_ovf", 32'(overflow_cnt), 32'd0);
    chk("t4_head", bus.out_data, 32'd17);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain", bus.out_data, (i < 7) ? 32'(17 + i) : 32'hA);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;

    // 5: async reset mid-operation
    pulse_reset();
    store(32'd80, 32'd1);
    store(32'd80, 32'd2);
    store(32'd84, 32'd7);
    chk("t5_pass_before", 32'(pass), 32'd1);
    chk("t5_count_before", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("t5_count_rst", 32'(count), 32'd0);
    chk("t5_valid_rst", 32'(bus.out_valid), 32'd0);
    chk("t5_done_rst", 32'(done), 32'd0);
    chk("t5_pass_rst", 32'(pass), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    store(32'd84, 32'd7);
    chk("t5_pass_again", 32'(pass), 32'd1);
    chk("t5_count_again", 32'(count), 32'd1);

    // 6: empty with out_ready held
    pulse_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_no_underflow", 32'(count), 32'd0);
    store(32'd80, 32'd9);
    chk("t6_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_data", bus.out_data, 32'd9);
    @(negedge clk);
    chk("t6_popped", 32'(bus.out_valid), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    bus.out_ready = 1'b0;

    // Randomized traffic, model-checked every cycle
    pulse_reset();
    for (int c = 0; c < 1500; c++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      bus.memwrite  = ($urandom_range(0, 99) < 60);
      bus.out_ready = ($urandom_range(0, 99) < 40);
      if (r < 92) begin
        bus.dataadr   = 32'd80;
        bus.writedata = 32'($urandom_range(0, 255));
      end else if (r < 96) begin
        bus.dataadr   = 32'd84;
        bus.writedata = ($urandom_range(0, 1) == 0) ? 32'd7 : 32'($urandom);
      end else begin
        bus.dataadr   = 32'($urandom);
        bus.writedata = 32'($urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
      @(negedge clk);
    end
    bus.memwrite  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
